// File: rtl/kmu_task_scheduler.sv
// kmu_task_scheduler: credit-based round-robin task dispatcher.
// Accepts one task at a time from the cluster input and routes it to the next
// socket, in circular order, that still has spare in-flight capacity. Each
// socket's capacity is counted by a small credit counter. A drain handshake
// empties the block before the sockets are reconfigured or reset.
// Optional build macro TASK_SCHED_PERF_EN adds dispatch and stall counters.

// Per-socket in-flight counter. A credit is reserved when a task is accepted
// for this socket and returned on the socket's task_done pulse.
module kmu_task_sched_credit #(
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_WIDTH    = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic eligible,
  output logic nonzero,
  output logic zero_nxt
);
  logic [CNT_WIDTH-1:0] credit, credit_nxt;

  // Next count: inc and dec together cancel; a dec with nothing in flight is dropped.
  always_comb begin
    credit_nxt = credit;
    if (inc && !dec)
      credit_nxt = credit + 1'b1;
    else if (dec && !inc && credit != '0)
      credit_nxt = credit - 1'b1;
  end

  // Credit register.
  always_ff @(posedge clk) begin
    if (reset) credit <= '0;
    else       credit <= credit_nxt;
  end

  // Eligibility uses the registered count, so a completion only frees capacity next cycle.
  assign eligible = credit < CNT_WIDTH'(MAX_INFLIGHT);
  assign nonzero  = credit != '0;
  assign zero_nxt = credit_nxt == '0;

  // A completion for a socket that has nothing in flight is an upstream bug.
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(dec && credit == '0));
endmodule

module kmu_task_scheduler #(
  parameter int NUM_SOCKETS  = 4,
  parameter int TASK_WIDTH   = 64,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   task_in_valid,
  input  logic [TASK_WIDTH-1:0]  task_in_data,
  output logic                   task_in_ready,
  output logic [NUM_SOCKETS-1:0] task_out_valid,
  output logic [TASK_WIDTH-1:0]  task_out_data,
  input  logic [NUM_SOCKETS-1:0] task_out_ready,
  input  logic [NUM_SOCKETS-1:0] task_done,
  input  logic                   drain_req,
  output logic                   drain_done,
  output logic                   busy
`ifdef TASK_SCHED_PERF_EN
  ,
  output logic [31:0]            perf_dispatched,
  output logic [31:0]            perf_stall_cycles
`endif
);
  localparam int CNT_WIDTH = $clog2(MAX_INFLIGHT + 1);
  localparam int PTR_W     = (NUM_SOCKETS > 1) ? $clog2(NUM_SOCKETS) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

  state_t                 state;
  logic [PTR_W-1:0]       rr_ptr, sel, rr_nxt;
  logic [PTR_W:0]         idx;
  logic [NUM_SOCKETS-1:0] elig, nonzero, zero_nxt, sel_oh, inc;
  logic [NUM_SOCKETS-1:0] out_valid_q;
  logic [TASK_WIDTH-1:0]  out_data_q;
  logic                   any_elig, out_fire, hold_free, accept, hold_empty_nxt;

  // Circular search for the first eligible socket starting at rr_ptr.
  always_comb begin
    sel      = '0;
    any_elig = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_SOCKETS; i++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_SOCKETS)) idx = idx - (PTR_W+1)'(NUM_SOCKETS);
      if (!any_elig && elig[idx[PTR_W-1:0]]) begin
        any_elig = 1'b1;
        sel      = idx[PTR_W-1:0];
      end
    end
  end

  // One-hot select and pointer advance past the granted socket.
  always_comb begin
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
    if (sel == PTR_W'(NUM_SOCKETS - 1)) rr_nxt = '0;
    else                                rr_nxt = sel + 1'b1;
  end

  assign out_fire       = |(out_valid_q & task_out_ready);
  assign hold_free      = !(|out_valid_q) || out_fire;
  assign task_in_ready  = !reset && (state == RUN) && any_elig && hold_free;
  assign accept         = task_in_valid && task_in_ready;
  assign inc            = accept ? sel_oh : '0;
  assign hold_empty_nxt = !accept && hold_free;

  for (genvar s = 0; s < NUM_SOCKETS; s++) begin : g_sock
    kmu_task_sched_credit #(
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .CNT_WIDTH    (CNT_WIDTH)
    ) u_credit (
      .clk      (clk),
      .reset    (reset),
      .inc      (inc[s]),
      .dec      (task_done[s]),
      .eligible (elig[s]),
      .nonzero  (nonzero[s]),
      .zero_nxt (zero_nxt[s])
    );
  end

  // Holding register: capture on accept, clear once the chosen socket takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      rr_ptr      <= '0;
    end else if (accept) begin
      out_valid_q <= sel_oh;
      out_data_q  <= task_in_data;
      rr_ptr      <= rr_nxt;
    end else if (out_fire) begin
      out_valid_q <= '0;
    end
  end

  assign task_out_valid = out_valid_q;
  assign task_out_data  = out_data_q;
  assign busy           = (|out_valid_q) || (|nonzero);

  // Drain FSM; drain_done is registered alongside the state so it tracks DRAINED exactly.
  // DRAIN exits on next-cycle emptiness so drain_done rises right after the last completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      drain_done <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (drain_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!drain_req) begin
            state <= RUN;
          end else if (hold_empty_nxt && (&zero_nxt)) begin
            state      <= DRAINED;
            drain_done <= 1'b1;
          end
        end
        DRAINED: begin
          if (!drain_req) begin
            state      <= RUN;
            drain_done <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          drain_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef TASK_SCHED_PERF_EN
  // Dispatch and upstream-stall counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_dispatched   <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (out_fire) perf_dispatched <= perf_dispatched + 32'd1;
      if (state == RUN && task_in_valid && !task_in_ready)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_kmu_task_scheduler.sv
// Directed table-driven bench for kmu_task_scheduler (NUM_SOCKETS=4, MAX_INFLIGHT=2).
module tb_kmu_task_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic        task_in_valid;
  logic [63:0] task_in_data;
  logic        task_in_ready;
  logic [3:0]  task_out_valid;
  logic [63:0] task_out_data;
  logic [3:0]  task_out_ready;
  logic [3:0]  task_done;
  logic        drain_req;
  logic        drain_done;
  logic        busy;
`ifdef TASK_SCHED_PERF_EN
  logic [31:0] perf_dispatched;
  logic [31:0] perf_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kmu_task_scheduler #(.NUM_SOCKETS(4), .TASK_WIDTH(64), .MAX_INFLIGHT(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .task_in_valid  (task_in_valid),
    .task_in_data   (task_in_data),
    .task_in_ready  (task_in_ready),
    .task_out_valid (task_out_valid),
    .task_out_data  (task_out_data),
    .task_out_ready (task_out_ready),
    .task_done      (task_done),
    .drain_req      (drain_req),
    .drain_done     (drain_done),
    .busy           (busy)
`ifdef TASK_SCHED_PERF_EN
    ,
    .perf_dispatched   (perf_dispatched),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [63:0] data;
    logic [3:0]  ordy;
    logic [3:0]  done;
    logic        drq;
    logic        chk_rdy;
    logic        e_rdy;
    logic [3:0]  e_ov;
    logic [63:0] e_od;
    logic        e_busy;
    logic        e_dd;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] pl(input logic [7:0] x);
    return (x == 8'h00) ? 64'h0 : {32'hDEADBEEF, 24'h0, x};
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                              input logic [3:0] ordy, input logic [3:0] done, input logic drq,
                              input logic cr, input logic er, input logic [3:0] eov,
                              input logic [7:0] eod, input logic eb, input logic edd);
    vec_t t;
    t.rst = r; t.vld = v; t.data = pl(d); t.ordy = ordy; t.done = done; t.drq = drq;
    t.chk_rdy = cr; t.e_rdy = er; t.e_ov = eov; t.e_od = pl(eod); t.e_busy = eb; t.e_dd = edd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic [3:0] ordy,
                       input logic [3:0] done, input logic drq);
    reset = r; task_in_valid = v; task_in_data = pl(d);
    task_out_ready = ordy; task_done = done; drain_req = drq;
  endtask

  initial begin
    drive(1, 0, 8'h00, 4'hF, 4'h0, 0);

    // rst vld data ordy done drq | chk_rdy rdy ov od busy dd
    vecs.push_back(mk(1,1,8'h00,4'hF,4'h0,0, 1,0,4'h0,8'h00,0,0)); // reset state
    // round robin, all ready
    vecs.push_back(mk(0,1,8'hA0,4'hF,4'h0,0, 1,1,4'h0,8'h00,0,0));
    vecs.push_back(mk(0,1,8'hA1,4'hF,4'h0,0, 1,1,4'h1,8'hA0,1,0));
    vecs.push_back(mk(0,1,8'hA2,4'hF,4'h0,0, 1,1,4'h2,8'hA1,1,0));
    vecs.push_back(mk(0,1,8'hA3,4'hF,4'h0,0, 1,1,4'h4,8'hA2,1,0));
    vecs.push_back(mk(0,0,8'h00,4'hF,4'h0,0, 1,1,4'h8,8'hA3,1,0));
    vecs.push_back(mk(0,0,8'h00,4'hF,4'h0,0, 1,1,4'h0,8'hA3,1,0));
    // saturation
    vecs.push_back(mk(0,1,8'hB0,4'hF,4'h0,0, 1,1,4'h0,8'hA3,1,0));
    vecs.push_back(mk(0,1,8'hB1,4'hF,4'h0,0, 1,1,4'h1,8'hB0,1,0));
    vecs.push_back(mk(0,1,8'hB2,4'hF,4'h0,0, 1,1,4'h2,8'hB1,1,0));
    vecs.push_back(mk(0,1,8'hB3,4'hF,4'h0,0, 1,1,4'h4,8'hB2,1,0));
    vecs.push_back(mk(0,1,8'hC0,4'hF,4'h0,0, 1,0,4'h8,8'hB3,1,0));
    vecs.push_back(mk(0,1,8'hC0,4'hF,4'h4,0, 1,0,4'h0,8'hB3,1,0));
    vecs.push_back(mk(0,1,8'hC0,4'hF,4'h0,0, 1,1,4'h0,8'hB3,1,0));
    vecs.push_back(mk(0,0,8'h00,4'hF,4'h0,0, 1,0,4'h4,8'hC0,1,0));
    vecs.push_back(mk(1,0,8'h00,4'hF,4'h0,0, 1,0,4'h0,8'hC0,1,0));
    // back-pressure on socket 1 for 5 cycles
    vecs.push_back(mk(0,1,8'hD0,4'hF,4'h0,0, 1,1,4'h0,8'h00,0,0));
    vecs.push_back(mk(0,1,8'hD1,4'hD,4'h0,0, 1,1,4'h1,8'hD0,1,0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0,1,8'hD2,4'hD,4'h0,0, 1,0,4'h2,8'hD1,1,0));
    vecs.push_back(mk(0,1,8'hD2,4'hF,4'h0,0, 1,1,4'h2,8'hD1,1,0));
    vecs.push_back(mk(0,0,8'h00,4'hF,4'h0,0, 1,1,4'h4,8'hD2,1,0));
    vecs.push_back(mk(0,0,8'h00,4'hF,4'h0,0, 1,1,4'h0,8'hD2,1,0));
    // simultaneous accept + done on socket 0, then fill to prove credit[0] stayed 1
    vecs.push_back(mk(0,1,8'hE0,4'hF,4'h0,0, 1,1,4'h0,8'hD2,1,0));
    vecs.push_back(mk(0,1,8'hE1,4'hF,4'h1,0, 1,1,4'h8,8'hE0,1,0));
    vecs.push_back(mk(0,0,8'h00,4'hF,4'h0,0, 1,1,4'h1,8'hE1,1,0));
    vecs.push_back(mk(0,1,8'hF0,4'hF,4'h0,0, 1,1,4'h0,8'hE1,1,0));
    vecs.push_back(mk(0,1,8'hF1,4'hF,4'h0,0, 1,1,4'h2,8'hF0,1,0));
    vecs.push_back(mk(0,1,8'hF2,4'hF,4'h0,0, 1,1,4'h4,8'hF1,1,0));
    vecs.push_back(mk(0,1,8'hF3,4'hF,4'h0,0, 1,1,4'h8,8'hF2,1,0));
    vecs.push_back(mk(0,1,8'h50,4'hF,4'h0,0, 1,0,4'h1,8'hF3,1,0));
    vecs.push_back(mk(1,0,8'h00,4'hF,4'h0,0, 1,0,4'h0,8'hF3,1,0));
    // drain with three tasks outstanding
    vecs.push_back(mk(0,1,8'h60,4'hF,4'h0,0, 1,1,4'h0,8'h00,0,0));
    vecs.push_back(mk(0,1,8'h61,4'hF,4'h0,0, 1,1,4'h1,8'h60,1,0));
    vecs.push_back(mk(0,1,8'h62,4'hF,4'h0,0, 1,1,4'h2,8'h61,1,0));
    vecs.push_back(mk(0,0,8'h00,4'hF,4'h0,1, 0,0,4'h4,8'h62,1,0));
    vecs.push_back(mk(0,1,8'h70,4'hF,4'h0,1, 1,0,4'h0,8'h62,1,0));
    vecs.push_back(mk(0,0,8'h00,4'hF,4'h1,1, 1,0,4'h0,8'h62,1,0));
    vecs.push_back(mk(0,0,8'h00,4'hF,4'h2,1, 1,0,4'h0,8'h62,1,0));
    vecs.push_back(mk(0,0,8'h00,4'hF,4'h4,1, 1,0,4'h0,8'h62,1,0));
    vecs.push_back(mk(0,0,8'h00,4'hF,4'h0,1, 1,0,4'h0,8'h62,0,1));
    vecs.push_back(mk(0,0,8'h00,4'hF,4'h0,0, 1,0,4'h0,8'h62,0,1));
    vecs.push_back(mk(0,1,8'h80,4'hF,4'h0,0, 1,1,4'h0,8'h62,0,0));
    vecs.push_back(mk(0,0,8'h00,4'hF,4'h0,0, 1,1,4'h8,8'h80,1,0));
    vecs.push_back(mk(0,0,8'h00,4'hF,4'h8,0, 1,1,4'h0,8'h80,1,0));
    vecs.push_back(mk(0,0,8'h00,4'hF,4'h0,0, 1,1,4'h0,8'h80,0,0));

    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].data[7:0], vecs[i].ordy, vecs[i].done, vecs[i].drq);
      task_in_data = vecs[i].data;
      #1;
      if (vecs[i].chk_rdy) chk($sformatf("v%0d_in_ready", i), 64'(task_in_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("v%0d_out_valid", i), 64'(task_out_valid), 64'(vecs[i].e_ov));
      chk($sformatf("v%0d_out_data", i), task_out_data, vecs[i].e_od);
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
      chk($sformatf("v%0d_drain_done", i), 64'(drain_done), 64'(vecs[i].e_dd));
      @(posedge clk);
      #1;
    end

    // Reset mid-flight: build credits {2,1,0,0} with a task held for socket 0.
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 8'h10 + 8'(k), 4'hF, 4'h0, 0);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 8'h00, 4'h0, 4'hC, 0);
    #1;
    chk("mid_hold_ready", 64'(task_in_ready), 64'd0);
    chk("mid_hold_valid", 64'(task_out_valid), 64'h1);
    chk("mid_hold_data", task_out_data, pl(8'h14));
    @(posedge clk);
    #1;
    drive(0, 0, 8'h00, 4'h0, 4'h0, 0);
    #1;
    chk("mid_held_valid", 64'(task_out_valid), 64'h1);
    chk("mid_held_data", task_out_data, pl(8'h14));
    chk("mid_busy", 64'(busy), 64'd1);
    drive(1, 0, 8'h00, 4'h0, 4'h0, 0);
    @(posedge clk);
    #1;
    chk("rst_valid", 64'(task_out_valid), 64'h0);
    chk("rst_data", task_out_data, 64'h0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(task_in_ready), 64'd0);
    drive(0, 1, 8'h20, 4'hF, 4'h0, 0);
    #1;
    chk("post_rst_ready", 64'(task_in_ready), 64'd1);
    @(posedge clk);
    #1;
    drive(0, 0, 8'h00, 4'hF, 4'h0, 0);
    #1;
    chk("post_rst_sock0", 64'(task_out_valid), 64'h1);
    chk("post_rst_data", task_out_data, pl(8'h20));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
